freq_gate_counter: RTL and testbench

- Reciprocal-counting measurement core clocked by the PLL output clock (the ~99.998 MHz reference timebase).
- Waits for the PLL lock to be stable, then opens a gate on a rising edge of the measured signal.
- Counts signal edges and reference cycles, and closes the gate on the first signal edge after the programmed gate length.
- Presents edge_count/ref_count over a valid/ready handshake to the downstream SPI readout; frequency = edge_count * f_clk / ref_count.

---
 rtl/freq_gate_counter.sv | 210 +++++++++++++++++++++
 tb/tb_freq_gate_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_counter.sv
// Reciprocal-counting frequency measurement core.
// After a start request the core waits for a stable PLL lock and arms.
// The gate opens on the next rising edge of sig_in. While the gate is open
// the core counts sig_in edges and clk cycles. It closes the gate on the
// first signal edge at or after the programmed gate length.
// The result is then held on a valid/ready interface until it is consumed.
module freq_gate_counter #(
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int LOCK_STABLE = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              sig_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  edge_count,
  output logic [GATE_W-1:0] ref_count,
  output logic              overflow,
  output logic              lock_err
);

  localparam int LOCK_W = $clog2(LOCK_STABLE) + 1;
  localparam logic [GATE_W-1:0] REF_MAX  = '1;
  localparam logic [CNT_W-1:0]  EDGE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_ARMED,
    ST_GATE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sig_sync_q, sig_sync_d;
  logic                sig_hist_q, sig_hist_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [GATE_W-1:0]   gate_len_q, gate_len_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [GATE_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]    edge_count_q, edge_count_d;
  logic [GATE_W-1:0]   ref_count_q, ref_count_d;
  logic                overflow_q, overflow_d;
  logic                lock_err_q, lock_err_d;

  logic                sig_edge;
  logic                locked;
  logic [GATE_W-1:0]   ref_inc;
  logic [CNT_W-1:0]    edge_inc;
  logic [CNT_W-1:0]    edge_nxt;
  logic [GATE_W:0]     ref_plus1;
  logic                saturated;

  // Synchronizer shift chains and the edge-detect history bit.
  always_comb begin
    sig_sync_d  = {sig_sync_q[SYNC_STAGES-2:0], sig_in};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    sig_hist_d  = sig_sync_q[SYNC_STAGES-1];
  end

  assign sig_edge = sig_sync_q[SYNC_STAGES-1] & ~sig_hist_q;
  assign locked   = lock_sync_q[SYNC_STAGES-1];

  // Saturating increments shared by the timeout and gate counters.
  always_comb begin
    ref_inc   = (ref_cnt_q == REF_MAX) ? REF_MAX : ref_cnt_q + GATE_W'(1);
    edge_inc  = (edge_cnt_q == EDGE_MAX) ? EDGE_MAX : edge_cnt_q + CNT_W'(1);
    edge_nxt  = sig_edge ? edge_inc : edge_cnt_q;
    ref_plus1 = {1'b0, ref_cnt_q} + (GATE_W + 1)'(1);
    saturated = (ref_inc == REF_MAX) || (edge_nxt == EDGE_MAX);
  end

  // Measurement sequencing: next state, counters and result latching.
  always_comb begin
    state_d      = state_q;
    gate_len_d   = gate_len_q;
    lock_cnt_d   = lock_cnt_q;
    ref_cnt_d    = ref_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    edge_count_d = edge_count_q;
    ref_count_d  = ref_count_q;
    overflow_d   = overflow_q;
    lock_err_d   = lock_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (gate_len != '0)) begin
          gate_len_d = gate_len;
          overflow_d = 1'b0;
          lock_err_d = 1'b0;
          lock_cnt_d = '0;
          ref_cnt_d  = '0;
          edge_cnt_d = '0;
          state_d    = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        if (!locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_W'(LOCK_STABLE - 1)) begin
          ref_cnt_d = '0;
          state_d   = ST_ARMED;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end

      ST_ARMED: begin
        if (!locked) begin
          edge_count_d = '0;
          ref_count_d  = ref_cnt_q;
          lock_err_d   = 1'b1;
          state_d      = ST_DONE;
        end else if (sig_edge) begin
          ref_cnt_d  = '0;
          edge_cnt_d = '0;
          state_d    = ST_GATE;
        end else begin
          ref_cnt_d = ref_inc;
          if (ref_inc == REF_MAX) begin
            overflow_d   = 1'b1;
            edge_count_d = '0;
            ref_count_d  = REF_MAX;
            state_d      = ST_DONE;
          end
        end
      end

      ST_GATE: begin
        if (!locked) begin
          edge_count_d = edge_cnt_q;
          ref_count_d  = ref_cnt_q;
          lock_err_d   = 1'b1;
          state_d      = ST_DONE;
        end else begin
          ref_cnt_d  = ref_inc;
          edge_cnt_d = edge_nxt;
          if (sig_edge && (ref_plus1 >= {1'b0, gate_len_q})) begin
            edge_count_d = edge_nxt;
            ref_count_d  = ref_inc;
            overflow_d   = saturated;
            state_d      = ST_DONE;
          end else if (saturated) begin
            edge_count_d = edge_nxt;
            ref_count_d  = ref_inc;
            overflow_d   = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sig_sync_q   <= '0;
      sig_hist_q   <= 1'b0;
      lock_sync_q  <= '0;
      gate_len_q   <= '0;
      lock_cnt_q   <= '0;
      ref_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      edge_count_q <= '0;
      ref_count_q  <= '0;
      overflow_q   <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_sync_q   <= sig_sync_d;
      sig_hist_q   <= sig_hist_d;
      lock_sync_q  <= lock_sync_d;
      gate_len_q   <= gate_len_d;
      lock_cnt_q   <= lock_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      edge_count_q <= edge_count_d;
      ref_count_q  <= ref_count_d;
      overflow_q   <= overflow_d;
      lock_err_q   <= lock_err_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign edge_count   = edge_count_q;
  assign ref_count    = ref_count_q;
  assign overflow     = overflow_q;
  assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Testbench for freq_gate_counter.
// The stimulus process queues the expected result of each measurement.
// A monitor compares the DUT result whenever result_valid is high.
module tb_freq_gate_counter;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        sig_in;
  logic        start;
  logic [15:0] gate_len;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] edge_count;
  logic [15:0] ref_count;
  logic        overflow;
  logic        lock_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] edge_c;
    logic [15:0] ref_c;
    logic        ovf;
    logic        lerr;
    bit          ref_care;
  } exp_t;

  exp_t sb[$];

  // Stimulus controls for the signal generator
  bit   sig_en     = 1'b0;
  int   sig_period = 10;
  logic sig_manual = 1'b0;

  freq_gate_counter #(
    .CNT_W(16),
    .GATE_W(16),
    .LOCK_STABLE(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .sig_in(sig_in),
    .start(start),
    .gate_len(gate_len),
    .busy(busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .edge_count(edge_count),
    .ref_count(ref_count),
    .overflow(overflow),
    .lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value and records the outcome
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Builds one expected result record
  function automatic exp_t mkExp(input int e, input int r, input bit o, input bit l, input bit care);
    exp_t x;
    x.edge_c   = 16'(e);
    x.ref_c    = 16'(r);
    x.ovf      = o;
    x.lerr     = l;
    x.ref_care = care;
    return x;
  endfunction

  // Expected result for a periodic input: the gate spans ceil(G/P) whole periods
  function automatic exp_t periodicModel(input int p, input int g);
    int k;
    k = (g + p - 1) / p;
    return mkExp(k, k * p, 1'b0, 1'b0, 1'b1);
  endfunction

  // Signal generator: periodic square wave or a manually driven level
  initial begin
    int phase;
    phase  = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sig_en) begin
        sig_in = (phase < sig_period / 2);
        phase  = (phase + 1) % sig_period;
      end else begin
        sig_in = sig_manual;
        phase  = 0;
      end
    end
  end

  // Monitor: compares every presented result with the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual=valid expected=no result pending");
        end else begin
          e = sb[0];
          checkOutput("edge_count", edge_count, e.edge_c);
          if (e.ref_care) checkOutput("ref_count", ref_count, e.ref_c);
          checkOutput("overflow", overflow, e.ovf);
          checkOutput("lock_err", lock_err, e.lerr);
          checkOutput("busy_done", busy, 1);
          if (result_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start pulse and optionally queues its expected result
  task automatic applyStimulus(input logic [15:0] g, input exp_t e, input bit push);
    @(posedge clk);
    #1;
    start    = 1'b1;
    gate_len = g;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits until the result is consumed and the core is idle, with a bound
  task automatic waitDone(input int budget, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=no result after %0d cycles expected=result", name, budget);
      sb.delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_valid"}, result_valid, 0);
    checkOutput({tag, "_edge"}, edge_count, 0);
    checkOutput({tag, "_ref"}, ref_count, 0);
    checkOutput({tag, "_ovf"}, overflow, 0);
    checkOutput({tag, "_lerr"}, lock_err, 0);
  endtask

  // Global watchdog
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog actual=still running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int   p, g, n;
    exp_t e;

    rst_n        = 1'b1;
    start        = 1'b0;
    gate_len     = '0;
    result_ready = 1'b1;
    pll_locked   = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    waitCycles(3);
    rst_n = 1'b1;

    // Periodic signal, exact and non-multiple gate lengths
    sig_period = 10;
    sig_en     = 1'b1;
    waitCycles(20);
    applyStimulus(16'd100, periodicModel(10, 100), 1'b1);
    waitDone(2000, "g100");
    applyStimulus(16'd95, periodicModel(10, 95), 1'b1);
    waitDone(2000, "g95");
    applyStimulus(16'd101, periodicModel(10, 101), 1'b1);
    waitDone(2000, "g101");

    // Randomized periods and gate lengths
    repeat (8) begin
      p = $urandom_range(2, 20);
      g = $urandom_range(1, 300);
      $display("[TB] random measurement period=%0d gate_len=%0d", p, g);
      sig_period = p;
      waitCycles(5);
      applyStimulus(16'(g), periodicModel(p, g), 1'b1);
      waitDone(3000, "random");
    end

    // Lock glitch during WAIT_LOCK: a lone pulse before re-arming must be ignored
    sig_en     = 1'b0;
    sig_manual = 1'b0;
    waitCycles(5);
    applyStimulus(16'd50, periodicModel(10, 50), 1'b1);
    waitCycles(7);
    pll_locked = 1'b0;
    waitCycles(4);
    pll_locked = 1'b1;
    waitCycles(9);
    sig_manual = 1'b1;
    waitCycles(2);
    sig_manual = 1'b0;
    waitCycles(35);
    sig_period = 10;
    sig_en     = 1'b1;
    waitDone(1000, "lock_rearm");

    // Lock lost about 35 cycles into the gate: three edges counted
    sig_en     = 1'b0;
    sig_manual = 1'b0;
    waitCycles(5);
    applyStimulus(16'd1000, mkExp(3, 0, 1'b0, 1'b1, 1'b0), 1'b1);
    waitCycles(30);
    sig_period = 10;
    sig_en     = 1'b1;
    waitCycles(35);
    pll_locked = 1'b0;
    waitDone(200, "lock_loss");
    pll_locked = 1'b1;
    sig_en     = 1'b0;
    waitCycles(5);

    // No signal edges: armed timeout
    applyStimulus(16'd100, mkExp(0, 16'hFFFF, 1'b1, 1'b0, 1'b1), 1'b1);
    waitDone(70000, "armed_timeout");

    // Result held while ready is low; start pulses ignored
    sig_period = 10;
    sig_en     = 1'b1;
    waitCycles(5);
    result_ready = 1'b0;
    e = periodicModel(10, 40);
    applyStimulus(16'd40, e, 1'b1);
    n = 0;
    while (!result_valid && n < 1000) begin
      waitCycles(1);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL hold_valid actual=no valid expected=valid");
    end
    for (int i = 0; i < 50; i++) begin
      start    = i[0];
      gate_len = 16'd7;
      waitCycles(1);
    end
    start        = 1'b0;
    result_ready = 1'b1;
    waitCycles(1);
    checkOutput("post_ack_busy", busy, 0);
    checkOutput("post_ack_valid", result_valid, 0);
    checkOutput("post_ack_edge", edge_count, e.edge_c);
    checkOutput("post_ack_ref", ref_count, e.ref_c);
    checkOutput("post_ack_sb", sb.size(), 0);
    waitCycles(5);
    checkOutput("start_ignored_busy", busy, 0);

    // Asynchronous reset in the middle of a gate
    applyStimulus(16'd200, periodicModel(10, 200), 1'b1);
    waitCycles(60);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    sb.delete();
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(3);

    // A start with zero gate length keeps the core idle
    applyStimulus(16'd0, e, 1'b0);
    checkOutput("zero_gate_busy", busy, 0);
    waitCycles(20);
    checkOutput("zero_gate_busy_late", busy, 0);
    checkOutput("zero_gate_valid", result_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
